// File: rtl/mano_io_pkg.sv
// Shared types and constants for the basic-computer serial terminal unit.
package mano_io_pkg;

  localparam int IO_DATA_BITS = 8;
  localparam int BIT_IDX_W    = $clog2(IO_DATA_BITS);

  localparam logic IDLE_LINE = 1'b1;
  localparam logic START_BIT = 1'b0;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/mano_baud_tick.sv
// Bit-period counter. tick marks the last cycle of a bit period, half marks
// the cycle just before the midpoint. restart realigns the period to the
// cycle after it is asserted.
module mano_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic restart,
  output logic tick,
  output logic half
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] cnt;

  // Free-running modulo-CLKS_PER_BIT counter, zeroed by restart.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || (cnt == CNT_W'(CLKS_PER_BIT - 1))) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign half = (cnt == CNT_W'(CLKS_PER_BIT / 2 - 1));

endmodule

// File: rtl/mano_io_unit.sv
// Serial terminal interface for the basic computer: INPR/FGI receive path,
// OUTR/FGO transmit path, IEN and the registered interrupt request R.
// Optional macro MANO_IO_OVERRUN_EN adds the sticky overrun output.
module mano_io_unit
  import mano_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = IO_DATA_BITS
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic                 rx_in,
  output logic                 tx_out,
  input  logic                 inp_ack,
  input  logic                 out_ld,
  input  logic [DATA_BITS-1:0] out_data,
  input  logic                 ien_set,
  input  logic                 ien_clr,
  output logic [DATA_BITS-1:0] inpr,
  output logic                 fgi,
  output logic                 fgo,
  output logic                 ien,
  output logic                 irq
`ifdef MANO_IO_OVERRUN_EN
  ,
  output logic                 overrun
`endif
);

  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

  logic                 rx_s1, rx_s2;
  logic                 rx_fall;
  rx_state_e            rx_state;
  logic [BIT_IDX_W-1:0] rx_idx;
  logic [DATA_BITS-1:0] rx_shreg;
  logic                 rx_done;
  logic                 rx_restart, rx_tick, rx_half;

  tx_state_e            tx_state;
  logic [BIT_IDX_W-1:0] tx_idx;
  logic [BIT_IDX_W-1:0] tx_idx_nxt;
  logic [DATA_BITS-1:0] outr;
  logic                 tx_load;
  logic                 tx_tick, tx_half_unused;

  // Two-flop synchroniser for the asynchronous serial input.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= IDLE_LINE;
      rx_s2 <= IDLE_LINE;
    end else begin
      rx_s1 <= rx_in;
      rx_s2 <= rx_s1;
    end
  end

  // Falling edge seen one flop early so rx_s2 enters the start bit on the
  // same edge the bit counter restarts; the half tick then lands mid-bit.
  assign rx_fall    = (rx_s2 == IDLE_LINE) && (rx_s1 == START_BIT);
  assign rx_restart = ((rx_state == RX_IDLE) && rx_fall) ||
                      ((rx_state == RX_START) && rx_half && (rx_s2 == START_BIT));

  mano_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_tick (
    .CLK     (CLK),
    .rst_n   (rst_n),
    .restart (rx_restart),
    .tick    (rx_tick),
    .half    (rx_half)
  );

  // Receive FSM: start validation at mid-bit, then one sample per bit period.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_idx   <= '0;
      rx_done  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_half) begin
            if (rx_s2 == START_BIT) begin
              rx_state <= RX_DATA;
              rx_idx   <= '0;
            end else begin
              rx_state <= RX_IDLE;
            end
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            if (rx_idx == LAST_BIT) rx_state <= RX_STOP;
            else                    rx_idx   <= rx_idx + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_tick) begin
            rx_done  <= (rx_s2 == IDLE_LINE);
            rx_state <= RX_IDLE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // LSB-first deserialiser; holds its value from the last data bit until the
  // next frame, so rx_done can commit it a cycle after the stop sample.
  always_ff @(posedge CLK) begin
    if ((rx_state == RX_DATA) && rx_tick) rx_shreg <= {rx_s2, rx_shreg[DATA_BITS-1:1]};
  end

  // INPR and FGI: a completing byte takes priority over a same-cycle INP.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      inpr <= '0;
      fgi  <= 1'b0;
    end else if (rx_done) begin
      inpr <= rx_shreg;
      fgi  <= 1'b1;
    end else if (inp_ack) begin
      fgi  <= 1'b0;
    end
  end

`ifdef MANO_IO_OVERRUN_EN
  // Sticky overrun: a byte landing on an unread INPR.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n)              overrun <= 1'b0;
    else if (rx_done && fgi) overrun <= 1'b1;
    else if (inp_ack)        overrun <= 1'b0;
  end
`endif

  // FGO=1 only while idle, so a load during a frame is simply dropped.
  assign tx_load    = out_ld && fgo;
  assign tx_idx_nxt = tx_idx + 1'b1;

  mano_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_tick (
    .CLK     (CLK),
    .rst_n   (rst_n),
    .restart (tx_load),
    .tick    (tx_tick),
    .half    (tx_half_unused)
  );

  // OUTR only changes on an accepted OUT.
  always_ff @(posedge CLK) begin
    if (tx_load) outr <= out_data;
  end

  // Transmit FSM: registered line output, FGO restored at end of stop bit.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_idx   <= '0;
      fgo      <= 1'b1;
      tx_out   <= IDLE_LINE;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_load) begin
            tx_state <= TX_START;
            fgo      <= 1'b0;
            tx_out   <= START_BIT;
          end
        end
        TX_START: begin
          if (tx_tick) begin
            tx_state <= TX_DATA;
            tx_idx   <= '0;
            tx_out   <= outr[0];
          end
        end
        TX_DATA: begin
          if (tx_tick) begin
            if (tx_idx == LAST_BIT) begin
              tx_state <= TX_STOP;
              tx_out   <= IDLE_LINE;
            end else begin
              tx_idx   <= tx_idx_nxt;
              tx_out   <= outr[tx_idx_nxt];
            end
          end
        end
        TX_STOP: begin
          if (tx_tick) begin
            tx_state <= TX_IDLE;
            fgo      <= 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // IEN with clear priority; R is masked by a same-cycle clear so it falls
  // together with IEN when the interrupt cycle is entered.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      ien <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (ien_clr)      ien <= 1'b0;
      else if (ien_set) ien <= 1'b1;
      irq <= ien && !ien_clr && (fgi || fgo);
    end
  end

endmodule

// File: tb/tb_mano_io_unit.sv
// Bench for mano_io_unit with CLKS_PER_BIT=4. Stimulus pushes expected RX
// bytes and TX frames into queues; monitors pop and compare when the DUT
// presents a received byte or starts a transmit frame.
module tb_mano_io_unit;

  localparam int CPB = 4;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_in = 1'b1;
  logic       inp_ack = 1'b0;
  logic       out_ld = 1'b0;
  logic [7:0] out_data = 8'h00;
  logic       ien_set = 1'b0;
  logic       ien_clr = 1'b0;
  logic       tx_out;
  logic [7:0] inpr;
  logic       fgi, fgo, ien, irq;
`ifdef MANO_IO_OVERRUN_EN
  logic       overrun;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  bit tx_mon_en = 1'b0;

  mano_io_unit #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .rx_in    (rx_in),
    .tx_out   (tx_out),
    .inp_ack  (inp_ack),
    .out_ld   (out_ld),
    .out_data (out_data),
    .ien_set  (ien_set),
    .ien_clr  (ien_clr),
    .inpr     (inpr),
    .fgi      (fgi),
    .fgo      (fgo),
    .ien      (ien),
    .irq      (irq)
`ifdef MANO_IO_OVERRUN_EN
    ,
    .overrun  (overrun)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    if (stop_bit) rx_q.push_back(b);
    rx_in = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      cyc(CPB);
    end
    rx_in = stop_bit;
    cyc(CPB);
    rx_in = 1'b1;
  endtask

  task automatic wait_fgo(input int maxc);
    int c = 0;
    while (!fgo && c < maxc) begin
      cyc(1);
      c++;
    end
    chk("fgo_wait_bound", fgo, 1);
  endtask

  // RX monitor: a new byte is presented when FGI rises or INPR changes under FGI.
  initial begin : rx_mon
    logic       pf;
    logic [7:0] pi;
    logic [7:0] e;
    pf = 1'b0;
    pi = 8'h00;
    forever begin
      @(negedge CLK);
      if (fgi && (!pf || inpr != pi)) begin
        if (rx_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rx_unexpected: got 0x%0h, expected no byte", inpr);
        end else begin
          e = rx_q.pop_front();
          chk("rx_byte", inpr, e);
        end
      end
      pf = fgi;
      pi = inpr;
    end
  end

  // TX monitor: a frame starts when FGO falls; capture 40 cycles of line.
  initial begin : tx_mon
    logic        pg;
    logic [7:0]  e;
    logic [9:0]  frame;
    logic [39:0] obs, expw;
    pg = 1'b1;
    forever begin
      @(negedge CLK);
      if (tx_mon_en && pg && !fgo) begin
        if (tx_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL tx_unexpected: got frame start, expected none");
        end else begin
          e = tx_q.pop_front();
          frame = {1'b1, e, 1'b0};
          for (int j = 0; j < 40; j++) expw[j] = frame[j / CPB];
          obs[0] = tx_out;
          for (int k = 2; k <= 40; k++) begin
            @(negedge CLK);
            obs[k-1] = tx_out;
          end
          chk("tx_waveform", obs, expw);
          chk("tx_fgo_busy_c39", fgo, 0);
          @(negedge CLK);
          chk("tx_fgo_set_c40", fgo, 1);
        end
      end
      pg = fgo;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    cyc(3);
    chk("rst_inpr", inpr, 0);
    chk("rst_fgi", fgi, 0);
    chk("rst_fgo", fgo, 1);
    chk("rst_ien", ien, 0);
    chk("rst_irq", irq, 0);
    chk("rst_tx_out", tx_out, 1);
    rst_n = 1'b1;
    cyc(2);

    // Reset in the middle of both a TX frame and an RX frame
    out_data = 8'h99;
    out_ld = 1'b1;
    cyc(1);
    out_ld = 1'b0;
    cyc(2);
    chk("t1_tx_start_bit", tx_out, 0);
    rx_in = 1'b0; cyc(CPB);
    rx_in = 1'b1; cyc(CPB);
    rx_in = 1'b0; cyc(2);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_inpr", inpr, 0);
    chk("t1_async_fgi", fgi, 0);
    chk("t1_async_fgo", fgo, 1);
    chk("t1_async_ien", ien, 0);
    chk("t1_async_irq", irq, 0);
    chk("t1_async_tx_out", tx_out, 1);
    rx_in = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    cyc(50);
    chk("t1_no_stale_fgi", fgi, 0);
    chk("t1_no_stale_inpr", inpr, 0);
    chk("t1_idle_tx_out", tx_out, 1);
    tx_mon_en = 1'b1;

    // Receive 0xA5, then INP
    send_byte(8'hA5, 1'b1);
    chk("t2_fgi_not_before_commit", fgi, 0);
    cyc(1);
    chk("t2_fgi_after_stop_sample", fgi, 1);
    chk("t2_inpr", inpr, 8'hA5);
    cyc(2);
    inp_ack = 1'b1;
    cyc(1);
    inp_ack = 1'b0;
    chk("t2_fgi_cleared", fgi, 0);
    chk("t2_inpr_held", inpr, 8'hA5);

    // Transmit 0x3C with an ignored mid-frame OUT of 0xFF
    tx_q.push_back(8'h3C);
    out_data = 8'h3C;
    out_ld = 1'b1;
    cyc(1);
    out_ld = 1'b0;
    chk("t3_fgo_cleared", fgo, 0);
    cyc(14);
    out_data = 8'hFF;
    out_ld = 1'b1;
    cyc(1);
    out_ld = 1'b0;
    wait_fgo(100);
    cyc(3);
    chk("t3_tx_idle", tx_out, 1);

    // Back-to-back frames without INP
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    cyc(CPB);
    chk("t4_inpr_overwritten", inpr, 8'h22);
    chk("t4_fgi", fgi, 1);
`ifdef MANO_IO_OVERRUN_EN
    chk("t4_overrun_set", overrun, 1);
`endif
    inp_ack = 1'b1;
    cyc(1);
    inp_ack = 1'b0;
    chk("t4_fgi_cleared", fgi, 0);
`ifdef MANO_IO_OVERRUN_EN
    chk("t4_overrun_cleared", overrun, 0);
`endif

    // One-cycle glitch, then a framing error, then a clean frame
    rx_in = 1'b0;
    cyc(1);
    rx_in = 1'b1;
    cyc(12);
    chk("t5_glitch_fgi", fgi, 0);
    chk("t5_glitch_inpr", inpr, 8'h22);
    send_byte(8'h55, 1'b0);
    cyc(12);
    chk("t5_frame_err_fgi", fgi, 0);
    chk("t5_frame_err_inpr", inpr, 8'h22);
`ifdef MANO_IO_OVERRUN_EN
    chk("t5_frame_err_overrun", overrun, 0);
`endif
    send_byte(8'hC3, 1'b1);
    cyc(CPB);
    chk("t5_recover_inpr", inpr, 8'hC3);
    inp_ack = 1'b1;
    cyc(1);
    inp_ack = 1'b0;

    // Interrupt enable and request
    chk("t6_fgo_ready", fgo, 1);
    ien_set = 1'b1;
    cyc(1);
    ien_set = 1'b0;
    chk("t6_ien_set", ien, 1);
    cyc(1);
    chk("t6_irq_raised", irq, 1);
    ien_set = 1'b1;
    ien_clr = 1'b1;
    cyc(1);
    ien_set = 1'b0;
    ien_clr = 1'b0;
    chk("t6_ien_clr_wins", ien, 0);
    chk("t6_irq_dropped", irq, 0);
    cyc(2);
    chk("t6_irq_stays_low", irq, 0);

    cyc(5);
    chk("rx_queue_drained", rx_q.size(), 0);
    chk("tx_queue_drained", tx_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
